// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: walks the 16 decoder lines in ascending order,
// skipping masked-off lines and holding each selected line for a
// programmable dwell time. Supports one-shot and continuous frames, a
// stop request that lets the current line finish, and a frame-done pulse.
//
// Handshake: start is a level request sampled every clk; it is honoured
// only when idle, stop is low and the sampled mask is non-zero. While
// busy, start is ignored. stop is also sampled every clk; in IDLE it
// overrides start, and while busy it ends the frame after the current
// line's dwell. All outputs come straight from flops.
module scan_index_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [15:0]        mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         index,
    output logic               index_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DWELL = 1'b1;

    logic [0:0]         state_q,     state_d;
    logic [3:0]         index_q,     index_d;
    logic               valid_q,     valid_d;
    logic               busy_q,      busy_d;
    logic               fd_q,        fd_d;
    logic [15:0]        mask_q,      mask_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic               cont_q,      cont_d;
    logic               stop_pend_q, stop_pend_d;
    logic [DWELL_W-1:0] cnt_q,       cnt_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [4:0]         first_in;
    logic [4:0]         next_line;
    logic               stop_eff;

    // Lowest set bit of m at or above position lo; bit 4 flags "found".
    function automatic logic [4:0] find_from(input logic [15:0] m, input logic [4:0] lo);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (i >= int'(lo))) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    // Search results and the effective dwell (0 behaves as 1).
    always_comb begin
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        first_in  = find_from(mask, 5'd0);
        next_line = find_from(mask_q, {1'b0, index_q} + 5'd1);
        stop_eff  = stop_pend_q | stop;
    end

    // Next-state logic: frame start, line stepping, frame end and stop.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        fd_d        = 1'b0;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop && (mask != 16'd0)) begin
                    mask_d  = mask;
                    dwell_d = dwell_eff;
                    cont_d  = continuous;
                    cnt_d   = dwell_eff;
                    index_d = first_in[3:0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_DWELL;
                end
            end

            default: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q != DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (next_line[4] && !stop_eff) begin
                    // Next enabled line follows with no gap cycle.
                    index_d = next_line[3:0];
                    cnt_d   = dwell_q;
                end else if (next_line[4]) begin
                    // Stopped before the last line: no completion pulse.
                    state_d     = ST_IDLE;
                    valid_d     = 1'b0;
                    busy_d      = 1'b0;
                    stop_pend_d = 1'b0;
                end else begin
                    // Last enabled line expired: frame complete.
                    fd_d = 1'b1;
                    if (cont_q && !stop_eff && (mask != 16'd0)) begin
                        mask_d  = mask;
                        dwell_d = dwell_eff;
                        cont_d  = continuous;
                        cnt_d   = dwell_eff;
                        index_d = first_in[3:0];
                    end else begin
                        state_d     = ST_IDLE;
                        valid_d     = 1'b0;
                        busy_d      = 1'b0;
                        stop_pend_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            index_q     <= 4'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fd_q        <= 1'b0;
            mask_q      <= 16'd0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fd_q        <= fd_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign index       = index_q;
    assign index_valid = valid_q;
    assign busy        = busy_q;
    assign frame_done  = fd_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Bench for scan_index_sequencer: directed scenarios followed by random
// traffic, all checked every cycle against a schedule-queue reference.
module tb_scan_index_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] mask;
    logic [7:0]  dwell;
    logic [3:0]  index;
    logic        index_valid;
    logic        busy;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame is a queue of line numbers, one per cycle.
    int sched[$];
    int m_idx;
    bit m_valid, m_busy, m_fd, m_cont, m_stop, m_stop_last;

    scan_index_sequencer #(.DWELL_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .mask        (mask),
        .dwell       (dwell),
        .index       (index),
        .index_valid (index_valid),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [15:0] m, input logic [7:0] d);
        int reps;
        reps = (d == 8'd0) ? 1 : int'(d);
        sched.delete();
        for (int line = 0; line < 16; line++) begin
            if (m[line]) begin
                for (int k = 0; k < reps; k++) sched.push_back(line);
            end
        end
    endfunction

    function automatic void model_idle();
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_stop  = 1'b0;
    endfunction

    function automatic void model_reset();
        sched.delete();
        m_idx = 0;
        m_fd = 1'b0;
        m_cont = 1'b0;
        m_stop_last = 1'b0;
        model_idle();
    endfunction

    // Advance the reference by one clock edge using the sampled inputs.
    function automatic void model_step();
        int keep[$];
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_fd = 1'b0;
        if (!m_busy) begin
            if (start && !stop && (mask != 16'd0)) begin
                build_frame(mask, dwell);
                m_cont  = continuous;
                m_stop  = 1'b0;
                m_idx   = sched.pop_front();
                m_valid = 1'b1;
                m_busy  = 1'b1;
            end
        end else begin
            if (stop && !m_stop) begin
                // Keep only the rest of the current line.
                m_stop = 1'b1;
                m_stop_last = 1'b1;
                foreach (sched[k]) begin
                    if (sched[k] == m_idx) keep.push_back(sched[k]);
                    else m_stop_last = 1'b0;
                end
                sched = keep;
            end
            if (sched.size() > 0) begin
                m_idx = sched.pop_front();
            end else if (m_stop) begin
                m_fd = m_stop_last;
                model_idle();
            end else begin
                m_fd = 1'b1;
                if (m_cont && (mask != 16'd0)) begin
                    build_frame(mask, dwell);
                    m_cont = continuous;
                    m_idx  = sched.pop_front();
                end else begin
                    model_idle();
                end
            end
        end
    endfunction

    task automatic compare_outputs();
        check_eq("index", 32'(index), 32'(m_idx));
        check_eq("index_valid", 32'(index_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: model follows the edge, outputs checked at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without an edge.
    task automatic async_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_index", 32'(index), 32'd0);
        check_eq("rst_valid", 32'(index_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        run(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        mask = 16'd0;
        dwell = 8'd0;
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(2);

        // Reset mid-frame, then no pulse after release.
        mask = 16'hFFFF; dwell = 8'd3; continuous = 1'b0;
        pulse_start();
        run(4);
        async_reset(3);
        run(6);

        // One-shot full scan.
        mask = 16'hFFFF; dwell = 8'd2; continuous = 1'b0;
        pulse_start();
        run(36);

        // Sparse mask, dwell 0 behaves as 1.
        mask = 16'h8421; dwell = 8'd0;
        pulse_start();
        run(8);

        // Continuous with relatch to a new mask.
        mask = 16'h0003; dwell = 8'd1; continuous = 1'b1;
        pulse_start();
        mask = 16'h0010;
        run(8);
        continuous = 1'b0;
        run(6);

        // Stop in the middle of line 3.
        mask = 16'h00FF; dwell = 8'd4; continuous = 1'b1;
        pulse_start();
        run(13);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(8);
        start = 1'b1; stop = 1'b1;
        run(3);
        start = 1'b0; stop = 1'b0;
        run(2);

        // Ignored requests: empty mask, start while busy.
        mask = 16'd0;
        pulse_start();
        run(3);
        mask = 16'h0505; dwell = 8'd3; continuous = 1'b0;
        pulse_start();
        mask = 16'hF000;
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; cycle();
            start = 1'b0; cycle();
        end
        run(6);

        // Maximum dwell on the top line.
        mask = 16'h8000; dwell = 8'hFF;
        pulse_start();
        run(260);

        // Single line, continuous: repeated frame_done.
        mask = 16'h0040; dwell = 8'd3; continuous = 1'b1;
        pulse_start();
        run(12);
        stop = 1'b1; cycle(); stop = 1'b0;
        run(5);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) begin
                continuous = 1'($urandom_range(0, 1));
                dwell = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40))
                                                      : 8'($urandom_range(0, 4));
                case ($urandom_range(0, 3))
                    0: mask = 16'($urandom);
                    1: mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    2: mask = 16'd1 << $urandom_range(0, 15);
                    default: mask = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'hFFFF;
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                async_reset(2);
            end else begin
                cycle();
            end
        end
        start = 1'b0; stop = 1'b0; continuous = 1'b0;
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_index_sequencer.md
Name: scan_index_sequencer

Overview:
- Upstream driver for the 4-to-16 line decoder: generates the 4-bit line index that the decoder expands to one-hot select lines.
- Steps through the 16 lines in ascending order, skips masked-off lines and holds each line for a programmable dwell time.
- Supports one-shot and continuous frames, a stop request and a frame-done pulse.
- index_valid gates the decoder output: decoder outputs are ignored while index_valid=0.

Parameters:
DWELL_W, 8, width of dwell input and internal dwell counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start request, sampled each clk
stop  input  1  stop request, sampled each clk
continuous  input  1  1=restart frame automatically, 0=one-shot; sampled at frame start
mask  input  16  line enable, bit i=1 scans line i; sampled at frame start
dwell  input  DWELL_W  cycles each line is held; sampled at frame start; 0 treated as 1
index  output  4  current line number to decoder in[3:0]
index_valid  output  1  index is an active selection
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on frame completion

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All other inputs are synchronous to clk.
- Reset: asserting rst_n low forces state=IDLE, index=0, index_valid=0, busy=0, frame_done=0 and clears all latched mask/dwell/mode/stop-pending registers immediately. This applies mid-frame; there is no completion pulse.
- Outputs are registered with no combinational path from inputs to outputs.
- States: IDLE and DWELL.
- IDLE:
  - index holds its last value; index_valid=0; busy=0.
  - start=1 with stop=0 and mask!=0: latch mask_q, dwell_q (0->1) and cont_q.
  - Next cycle: state=DWELL, index=lowest set bit of mask_q, index_valid=1, busy=1.
  - start with mask==0 is ignored; outputs do not change.
  - start and stop asserted together in IDLE: stop wins and start is ignored.
- DWELL:
  - Each selected line is held for exactly dwell_q cycles with index_valid=1.
  - The next line is the lowest set bit of mask_q strictly above the current index, found in the same cycle by priority search. There is no gap cycle between lines.
  - start is ignored while busy.
  - Input mask, dwell and continuous changes take effect only at the next frame start.
- End of frame (dwell of the highest enabled line expires):
  - frame_done pulses in the following cycle.
  - If cont_q=1 and no stop is pending, that same cycle relatches mask, dwell and continuous and presents the lowest enabled line with index_valid=1 (zero idle gap).
  - If the relatched mask==0, go to IDLE instead.
  - Otherwise go to IDLE with index_valid=0 and busy=0 in the frame_done cycle.
- stop while busy:
  - Sets stop_pend. The current line completes its full dwell, then state=IDLE.
  - No further lines are selected.
  - frame_done pulses only if the stopped line was the last enabled line of the frame.
  - stop_pend clears on entry to IDLE.
- Counter wrap: the dwell counter counts down from dwell_q to 1. The maximum dwell is 2^DWELL_W-1 cycles. The index never wraps past 15 within a frame.
- Single enabled line with cont_q=1: the same index is held continuously, with a frame_done pulse every dwell_q cycles.

Test Plan:
- Reset mid-frame: mask=16'hFFFF, dwell=3, start; assert rst_n low at cycle 5 -> index=0, index_valid=0, busy=0 and frame_done=0 immediately; no pulse after release.
- One-shot full scan: mask=16'hFFFF, dwell=2, continuous=0, start 1 cycle -> index 0..15, each valid for 2 cycles (32 cycles total); frame_done high for 1 cycle; then busy=0 and index_valid=0.
- Sparse mask and dwell=0: mask=16'h8421, dwell=0 -> index sequence 0,5,10,15 with 1 cycle each; frame_done on the 5th cycle after the first valid.
- Continuous with relatch: mask=16'h0003, dwell=1, continuous=1; change mask to 16'h0010 mid-frame -> 0,1 then frame_done coincident with index=4 valid; subsequent frames show only 4.
- Stop mid-line: mask=16'h00FF, dwell=4, continuous=1; stop during cycle 2 of line 3 -> line 3 is held its full 4 cycles, then IDLE with no frame_done; start+stop together in IDLE -> no activity.
- Ignored requests: start with mask=0 -> busy stays 0; start pulses while busy -> sequence unchanged.
